// File: rtl/cpsr_flag_unit.sv
// cpsr_flag_unit: ARM condition check and NZCV update feeding the CPSR storage register.
// Optional feature macro CPSR_FWD_EN: conditions read the shadow flags and never stall.
module cpsr_flag_unit #(
  parameter int               FULLW      = 32,
  parameter logic [FULLW-1:0] RESET_CPSR = 32'h0000_00D3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic             in_setf,
  input  logic             in_arith,
  input  logic [31:0]      in_result,
  input  logic             in_c_alu,
  input  logic             in_v_alu,
  input  logic             in_c_shift,
  input  logic             in_msr,
  input  logic [31:0]      in_msr_data,
  input  logic [FULLW-1:0] cpsr_q,
  output logic             cpsr_we,
  output logic [FULLW-1:0] cpsr_d,
  output logic             exec_q,
  output logic [3:0]       flags_o
);

  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_reg;
  logic             rdy_reg;
  logic [1:0]       hazard_reg;
  logic [FULLW-1:0] shadow_reg;
  logic             cpsr_we_reg;
  logic [FULLW-1:0] cpsr_d_reg;
  logic             exec_reg;

  logic [3:0]       src_flags;
  logic             n_f, z_f, c_f, v_f;
  logic             cond_pass;
  logic             accept;
  logic             flag_chg;
  logic [3:0]       new_flags;
  logic [FULLW-1:0] shadow_next;
  logic             unused_bits;

`ifdef CPSR_FWD_EN
  assign src_flags   = shadow_reg[31:28];
  assign in_ready    = rdy_reg;
  assign unused_bits = ^{cpsr_q, in_msr_data[27:0], hazard_reg};
`else
  // Stall only on the registered hazard count and in_cond, never on cpsr_q itself.
  assign src_flags   = cpsr_q[31:28];
  assign in_ready    = rdy_reg & ((hazard_reg == 2'd0) | (in_cond == COND_AL));
  assign unused_bits = ^{cpsr_q[27:0], in_msr_data[27:0]};
`endif

  assign {n_f, z_f, c_f, v_f} = src_flags;

  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = ~z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = ~c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = ~n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = ~v_f;
      4'h8:    cond_pass = c_f & ~z_f;
      4'h9:    cond_pass = ~c_f | z_f;
      4'hA:    cond_pass = (n_f == v_f);
      4'hB:    cond_pass = (n_f != v_f);
      4'hC:    cond_pass = ~z_f & (n_f == v_f);
      4'hD:    cond_pass = z_f | (n_f != v_f);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign flag_chg = accept & cond_pass & (in_msr | in_setf);

  // Logical ops keep V from the shadow so back-to-back updates stay cumulative.
  always_comb begin
    new_flags = shadow_reg[31:28];
    if (in_msr) begin
      new_flags = in_msr_data[31:28];
    end else begin
      new_flags = {in_result[31], (in_result == 32'd0),
                   in_arith ? in_c_alu : in_c_shift,
                   in_arith ? in_v_alu : shadow_reg[28]};
    end
    shadow_next = shadow_reg;
    shadow_next[31:28] = new_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= INIT;
      rdy_reg     <= 1'b0;
      hazard_reg  <= 2'd0;
      shadow_reg  <= RESET_CPSR;
      cpsr_we_reg <= 1'b0;
      cpsr_d_reg  <= '0;
      exec_reg    <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          state_reg   <= RUN;
          rdy_reg     <= 1'b0;
          hazard_reg  <= 2'd2;
          shadow_reg  <= RESET_CPSR;
          cpsr_we_reg <= 1'b1;
          cpsr_d_reg  <= RESET_CPSR;
          exec_reg    <= 1'b0;
        end
        default: begin
          rdy_reg     <= 1'b1;
          exec_reg    <= accept & cond_pass;
          cpsr_we_reg <= flag_chg;
          if (flag_chg) begin
            shadow_reg <= shadow_next;
            cpsr_d_reg <= shadow_next;
            hazard_reg <= 2'd2;
          end else if (hazard_reg != 2'd0) begin
            hazard_reg <= hazard_reg - 2'd1;
          end
        end
      endcase
    end
  end

  assign cpsr_we = cpsr_we_reg;
  assign cpsr_d  = cpsr_d_reg;
  assign exec_q  = exec_reg;
  assign flags_o = shadow_reg[31:28];

endmodule

// File: tb/tb_cpsr_flag_unit.sv
// Self-checking bench for cpsr_flag_unit: directed scenarios plus randomized ops against
// an architectural flag model, with a two-edge CPSR storage register modelled here.
module tb_cpsr_flag_unit;

  localparam logic [31:0] RESET_CPSR = 32'h0000_00D3;
  localparam logic [3:0]  RESET_HI   = RESET_CPSR[31:28];
  localparam logic [27:0] RESET_LO   = RESET_CPSR[27:0];
`ifdef CPSR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  in_cond = 4'hE;
  logic        in_setf = 1'b0, in_arith = 1'b0;
  logic [31:0] in_result = '0;
  logic        in_c_alu = 1'b0, in_v_alu = 1'b0, in_c_shift = 1'b0;
  logic        in_msr = 1'b0;
  logic [31:0] in_msr_data = '0;
  logic [31:0] cpsr_q = '0, cpsr_d, stg = '0;
  logic        cpsr_we, exec_q;
  logic [3:0]  flags_o;

  int          checks = 0, failures = 0;
  int          edge_cnt = 0, init_edge = 0, last_wr = 0;
  logic [3:0]  m_flags = 4'h0;
  logic        exp_ready, exp_exec, exp_we;
  logic [31:0] exp_d;

  cpsr_flag_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_setf(in_setf), .in_arith(in_arith), .in_result(in_result),
    .in_c_alu(in_c_alu), .in_v_alu(in_v_alu), .in_c_shift(in_c_shift),
    .in_msr(in_msr), .in_msr_data(in_msr_data), .cpsr_q(cpsr_q),
    .cpsr_we(cpsr_we), .cpsr_d(cpsr_d), .exec_q(exec_q), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  // Storage register: captures one edge after the write, visible after the next.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    stg      <= cpsr_we ? cpsr_d : stg;
    cpsr_q   <= stg;
  end

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cc;         4'h3: return !cc;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cc && !z;   4'h9: return !cc || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drives one cycle from posedge+1, samples in_ready, advances the model, ends at posedge+1.
  task automatic step(input logic v, input logic [3:0] c, input logic s, input logic ar,
                      input logic [31:0] res, input logic ca, input logic va, input logic cs,
                      input logic msr, input logic [31:0] md, output logic obs_rdy);
    int  e;
    logic acc;
    in_valid = v; in_cond = c; in_setf = s; in_arith = ar; in_result = res;
    in_c_alu = ca; in_v_alu = va; in_c_shift = cs; in_msr = msr; in_msr_data = md;
    #1;
    obs_rdy = in_ready;
    e = edge_cnt + 1;
    exp_ready = (e >= init_edge + 2) && (FWD || c == 4'hE || e >= last_wr + 3);
    acc = v && exp_ready;
    exp_exec = acc && cond_ok(c, m_flags);
    exp_we = exp_exec && (msr || s);
    if (exp_we) begin
      if (msr) m_flags = md[31:28];
      else m_flags = {res[31], res == 32'd0, ar ? ca : cs, ar ? va : m_flags[0]};
      last_wr = e;
    end
    exp_d = {m_flags, RESET_LO};
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) step(1'b0, 4'hE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_edge = edge_cnt + 1;
    last_wr = init_edge;
    m_flags = RESET_HI;
  endtask

  task automatic test_reset();
    logic r;
    rst_n = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", in_ready); end
    checks++; if (cpsr_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", cpsr_we); end
    checks++; if (cpsr_d !== 32'd0) begin failures++; $display("FAIL rst_d got=%h exp=0", cpsr_d); end
    checks++; if (exec_q !== 1'b0) begin failures++; $display("FAIL rst_exec got=%0b exp=0", exec_q); end
    checks++; if (flags_o !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", flags_o); end
    release_reset();
    step(1'b0, 4'hE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (cpsr_we !== 1'b1) begin failures++; $display("FAIL init_we got=%0b exp=1", cpsr_we); end
    checks++; if (cpsr_d !== RESET_CPSR) begin failures++; $display("FAIL init_d got=%h exp=%h", cpsr_d, RESET_CPSR); end
    step(1'b0, 4'hE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (r !== 1'b0) begin failures++; $display("FAIL init_ready got=%0b exp=0", r); end
    checks++; if (cpsr_we !== 1'b0) begin failures++; $display("FAIL init_we_drop got=%0b exp=0", cpsr_we); end
    step(1'b0, 4'h0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (r !== exp_ready) begin failures++; $display("FAIL post_init_eq_ready got=%0b exp=%0b", r, exp_ready); end
    step(1'b0, 4'hE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL post_init_al_ready got=%0b exp=1", r); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_adds();
    logic r;
    idle(3);
    step(1'b1, 4'hE, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, r);
    checks++; if (exec_q !== 1'b1) begin failures++; $display("FAIL adds_exec got=%0b exp=1", exec_q); end
    checks++; if (cpsr_we !== 1'b1) begin failures++; $display("FAIL adds_we got=%0b exp=1", cpsr_we); end
    checks++; if (cpsr_d[31:28] !== 4'b1001) begin failures++; $display("FAIL adds_nzcv got=%b exp=1001", cpsr_d[31:28]); end
    $display("test_adds cpsr_d=%h exec_q=%0b", cpsr_d, exec_q);
  endtask

  task automatic test_fwd_hazard();
    logic r, got;
    int   stalls;
    idle(3);
    step(1'b1, 4'hE, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (cpsr_d[31:28] !== 4'b0100) begin failures++; $display("FAIL setz_nzcv got=%b exp=0100", cpsr_d[31:28]); end
    stalls = 0; got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      step(1'b1, 4'h0, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
      checks++; if (r !== exp_ready) begin failures++; $display("FAIL eq_ready cyc=%0d got=%0b exp=%0b", k, r, exp_ready); end
      if (r === 1'b1) got = 1'b1; else stalls++;
    end
    checks++; if (!got) begin failures++; $display("FAIL eq_timeout got=stalled exp=accepted"); end
    checks++; if (stalls != (FWD ? 0 : 2)) begin failures++; $display("FAIL eq_stalls got=%0d exp=%0d", stalls, FWD ? 0 : 2); end
    checks++; if (exec_q !== 1'b1) begin failures++; $display("FAIL eq_exec got=%0b exp=1", exec_q); end
    $display("test_fwd_hazard stalls=%0d exec_q=%0b", stalls, exec_q);
  endtask

  task automatic test_ne_fail();
    logic r, got;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      step(1'b1, 4'h1, 1'b1, 1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, r);
      if (r === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL ne_timeout got=stalled exp=accepted"); end
    checks++; if (exec_q !== 1'b0) begin failures++; $display("FAIL ne_exec got=%0b exp=0", exec_q); end
    checks++; if (cpsr_we !== 1'b0) begin failures++; $display("FAIL ne_we got=%0b exp=0", cpsr_we); end
    checks++; if (flags_o !== 4'b0100) begin failures++; $display("FAIL ne_flags got=%b exp=0100", flags_o); end
    $display("test_ne_fail exec_q=%0b flags_o=%b", exec_q, flags_o);
  endtask

  task automatic test_back_to_back();
    logic r;
    step(1'b1, 4'hE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0000, r);
    checks++; if (cpsr_we !== 1'b1) begin failures++; $display("FAIL msr_we got=%0b exp=1", cpsr_we); end
    checks++; if (cpsr_d !== 32'hF000_00D3) begin failures++; $display("FAIL msr_d got=%h exp=f00000d3", cpsr_d); end
    step(1'b1, 4'hE, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, r);
    checks++; if (cpsr_we !== 1'b1) begin failures++; $display("FAIL ands_we got=%0b exp=1", cpsr_we); end
    checks++; if (cpsr_d !== 32'h3000_00D3) begin failures++; $display("FAIL ands_d got=%h exp=300000d3", cpsr_d); end
    $display("test_back_to_back cpsr_d=%h", cpsr_d);
  endtask

  task automatic test_random();
    logic r, v, s, ar, msr;
    logic [3:0] c;
    logic [31:0] res;
    int f0;
    f0 = failures;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 8);
      c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) c = 4'hE;
      s = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      res = $urandom;
      if ($urandom_range(0, 3) == 0) res = 32'd0;
      msr = ($urandom_range(0, 7) == 0);
      step(v, c, s, ar, res, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), msr, $urandom, r);
      checks++; if (r !== exp_ready) begin failures++; $display("FAIL rnd_ready i=%0d got=%0b exp=%0b", i, r, exp_ready); end
      checks++; if (exec_q !== exp_exec) begin failures++; $display("FAIL rnd_exec i=%0d got=%0b exp=%0b", i, exec_q, exp_exec); end
      checks++; if (cpsr_we !== exp_we) begin failures++; $display("FAIL rnd_we i=%0d got=%0b exp=%0b", i, cpsr_we, exp_we); end
      checks++; if (flags_o !== m_flags) begin failures++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, flags_o, m_flags); end
      if (exp_we) begin
        checks++; if (cpsr_d !== exp_d) begin failures++; $display("FAIL rnd_d i=%0d got=%h exp=%h", i, cpsr_d, exp_d); end
      end
    end
    $display("test_random ops=400 new_failures=%0d", failures - f0);
  endtask

  task automatic test_reset_mid();
    logic r;
    idle(3);
    step(1'b1, 4'hE, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (cpsr_we !== 1'b1) begin failures++; $display("FAIL mid_we_pre got=%0b exp=1", cpsr_we); end
    rst_n = 1'b0; #1;
    checks++; if (cpsr_we !== 1'b0) begin failures++; $display("FAIL mid_we_drop got=%0b exp=0", cpsr_we); end
    checks++; if (exec_q !== 1'b0) begin failures++; $display("FAIL mid_exec got=%0b exp=0", exec_q); end
    checks++; if (flags_o !== 4'b0000) begin failures++; $display("FAIL mid_flags got=%b exp=0000", flags_o); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0b exp=0", in_ready); end
    release_reset();
    step(1'b0, 4'hE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (cpsr_we !== 1'b1) begin failures++; $display("FAIL mid_init_we got=%0b exp=1", cpsr_we); end
    checks++; if (cpsr_d !== RESET_CPSR) begin failures++; $display("FAIL mid_init_d got=%h exp=%h", cpsr_d, RESET_CPSR); end
    step(1'b0, 4'hE, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, r);
    checks++; if (r !== 1'b0) begin failures++; $display("FAIL mid_init_ready got=%0b exp=0", r); end
    $display("test_reset_mid cpsr_we=%0b flags_o=%b", cpsr_we, flags_o);
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_adds();
    test_fwd_hazard();
    test_ne_fail();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
